// File: rtl/qupls4_agen_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler that shares one address generator among NREQ requesters.
// Runs one or two agen passes per op (two when the op crosses a cache line) and waits for TLB acceptance.
module qupls4_agen_sched #(
    parameter int NREQ = 4,
    parameter int TMO  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           xline,
    input  logic                      flush,
    input  logic                      tlb_v,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   sel,
    output logic                      agen_out,
    output logic                      agen_next,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      busy,
    output logic                      tmo_err
);

    localparam int SW = $clog2(NREQ);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   ptr_q;
    logic [TW-1:0]   timer_q;
    logic            xl_q;
    logic [NREQ-1:0] gnt_q;
    logic [SW-1:0]   sel_q;
    logic            agen_out_q;
    logic            agen_next_q;
    logic            done_q;
    logic [SW-1:0]   done_id_q;
    logic            busy_q;
    logic            tmo_q;

    logic            found_d;
    logic [SW-1:0]   pick_d;
    logic [SW-1:0]   ptr_d;
    logic [NREQ-1:0] gnt_d;
    logic [SW:0]     sum_d;
    logic [SW:0]     inc_d;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found_d = 1'b0;
        pick_d  = '0;
        sum_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_d = {1'b0, ptr_q} + (SW+1)'(k);
            if (sum_d >= (SW+1)'(NREQ))
                sum_d = sum_d - (SW+1)'(NREQ);
            if (!found_d && req[sum_d[SW-1:0]]) begin
                found_d = 1'b1;
                pick_d  = sum_d[SW-1:0];
            end
        end
        inc_d = {1'b0, pick_d} + (SW+1)'(1);
        ptr_d = (inc_d == (SW+1)'(NREQ)) ? '0 : inc_d[SW-1:0];
        gnt_d = NREQ'(1) << pick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            xl_q        <= 1'b0;
            gnt_q       <= '0;
            sel_q       <= '0;
            agen_out_q  <= 1'b0;
            agen_next_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            agen_out_q  <= 1'b0;
            agen_next_q <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                busy_q  <= 1'b0;
                timer_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (found_d) begin
                            sel_q      <= pick_d;
                            gnt_q      <= gnt_d;
                            xl_q       <= xline[pick_d];
                            ptr_q      <= ptr_d;
                            agen_out_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= REQ1;
                        end
                    end
                    REQ1: begin
                        timer_q <= '0;
                        state_q <= WAIT1;
                    end
                    WAIT1: begin
                        if (tlb_v && xl_q) begin
                            agen_out_q  <= 1'b1;
                            agen_next_q <= 1'b1;
                            state_q     <= REQ2;
                        end else if (tlb_v) begin
                            done_q    <= 1'b1;
                            done_id_q <= sel_q;
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else if (timer_q == TW'(TMO - 1)) begin
                            tmo_q   <= 1'b1;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    REQ2: begin
                        timer_q <= '0;
                        state_q <= WAIT2;
                    end
                    WAIT2: begin
                        if (tlb_v) begin
                            done_q    <= 1'b1;
                            done_id_q <= sel_q;
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else if (timer_q == TW'(TMO - 1)) begin
                            tmo_q   <= 1'b1;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    default: begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign agen_out  = agen_out_q;
    assign agen_next = agen_next_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign busy      = busy_q;
    assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_qupls4_agen_sched.sv
`timescale 1ns/1ps
// Bench for qupls4_agen_sched: per-scenario tasks with a done_id scoreboard queue.
module tb_qupls4_agen_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] xline;
    logic       flush;
    logic       tlb_v;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       agen_out;
    logic       agen_next;
    logic       done;
    logic [1:0] done_id;
    logic       busy;
    logic       tmo_err;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    qupls4_agen_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .xline(xline), .flush(flush), .tlb_v(tlb_v),
        .gnt(gnt), .sel(sel), .agen_out(agen_out), .agen_next(agen_next),
        .done(done), .done_id(done_id), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; xline = '0; flush = 1'b0; tlb_v = 1'b0;
        tick; tick;
        total++; if ({gnt, sel, agen_out, agen_next, done, done_id, busy, tmo_err} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs got=%0h exp=0", {gnt, sel, agen_out, agen_next, done, done_id, busy, tmo_err});
        end
        rst = 1'b0;
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_round_robin;
        int id;
        req = 4'b1111; tlb_v = 1'b1;
        tick;
        for (int g = 0; g < 5; g++) begin
            total++; if (sel !== 2'(g % 4)) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", g, sel, g % 4); end
            total++; if (gnt !== (4'b0001 << (g % 4))) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", g, gnt, 4'b0001 << (g % 4)); end
            total++; if ({agen_out, agen_next} !== 2'b10) begin bad++; $display("FAIL rr_agen[%0d] got=%b exp=10", g, {agen_out, agen_next}); end
            exp_q.push_back(g % 4);
            if (g == 4) req = '0;
            tick;
            total++; if ({agen_out, busy, done} !== 3'b010) begin bad++; $display("FAIL rr_wait1[%0d] got=%b exp=010", g, {agen_out, busy, done}); end
            tick;
            total++; if (done !== 1'b1) begin bad++; $display("FAIL rr_done[%0d] got=%0b exp=1", g, done); end
            else if (exp_q.size() > 0) begin
                id = exp_q.pop_front();
                total++; if (done_id !== 2'(id)) begin bad++; $display("FAIL rr_done_id[%0d] got=%0d exp=%0d", g, done_id, id); end
            end
            if (g < 4) tick;
        end
        tlb_v = 1'b0;
        tick;
        total++; if ({busy, agen_out, done} !== 3'b000) begin bad++; $display("FAIL rr_idle got=%b exp=000", {busy, agen_out, done}); end
    endtask

    task automatic test_single;
        int id;
        req = 4'b0100; xline = '0;
        tick;
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL single_sel got=%0d exp=2", sel); end
        total++; if ({agen_out, agen_next, busy} !== 3'b101) begin bad++; $display("FAIL single_agen got=%b exp=101", {agen_out, agen_next, busy}); end
        exp_q.push_back(2);
        req = '0;
        tick;
        tick;
        total++; if ({agen_out, done, gnt} !== 6'b000100) begin bad++; $display("FAIL single_wait got=%b exp=000100", {agen_out, done, gnt}); end
        tlb_v = 1'b1;
        tick;
        tlb_v = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%0b exp=1", done); end
        else if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            total++; if (done_id !== 2'(id)) begin bad++; $display("FAIL single_done_id got=%0d exp=%0d", done_id, id); end
        end
        total++; if ({gnt, busy} !== 5'b0) begin bad++; $display("FAIL single_idle got=%b exp=00000", {gnt, busy}); end
    endtask

    task automatic test_xline;
        int id;
        req = 4'b0010; xline = 4'b0010; tlb_v = 1'b1;
        tick;
        total++; if ({sel, agen_out, agen_next} !== 4'b0110) begin bad++; $display("FAIL xl_pass1 got=%b exp=0110", {sel, agen_out, agen_next}); end
        exp_q.push_back(1);
        req = '0; xline = '0;
        tick;
        total++; if ({agen_out, done} !== 2'b00) begin bad++; $display("FAIL xl_wait1 got=%b exp=00", {agen_out, done}); end
        tick;
        total++; if ({agen_out, agen_next, done, gnt} !== 7'b1100010) begin bad++; $display("FAIL xl_pass2 got=%b exp=1100010", {agen_out, agen_next, done, gnt}); end
        tick;
        total++; if ({agen_out, done, busy} !== 3'b001) begin bad++; $display("FAIL xl_wait2 got=%b exp=001", {agen_out, done, busy}); end
        tick;
        tlb_v = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL xl_done got=%0b exp=1", done); end
        else if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            total++; if (done_id !== 2'(id)) begin bad++; $display("FAIL xl_done_id got=%0d exp=%0d", done_id, id); end
        end
        tick;
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL xl_single_done got=%b exp=00", {done, busy}); end
    endtask

    task automatic test_timeout;
        int k;
        int ndone;
        req = 4'b1000; tlb_v = 1'b0;
        tick;
        total++; if (sel !== 2'd3) begin bad++; $display("FAIL tmo_sel got=%0d exp=3", sel); end
        req = '0;
        tick;
        k = 0; ndone = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick;
            if (done) ndone++;
            if (tmo_err) k = i;
        end
        total++; if (k !== TMO) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", k, TMO); end
        total++; if ({ndone, busy, gnt} !== {32'd0, 1'b0, 4'b0}) begin bad++; $display("FAIL tmo_state done_cnt=%0d busy=%0b gnt=%b exp=0/0/0000", ndone, busy, gnt); end
        req = 4'b1111; xline = 4'b0001;
        tick;
        total++; if ({sel, gnt} !== 6'b000001) begin bad++; $display("FAIL tmo_next_grant got=%b exp=000001", {sel, gnt}); end
    endtask

    task automatic test_flush;
        req = '0; xline = '0; tlb_v = 1'b1;
        tick;
        tick;
        total++; if ({agen_out, agen_next} !== 2'b11) begin bad++; $display("FAIL flush_pass2 got=%b exp=11", {agen_out, agen_next}); end
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0; tlb_v = 1'b0;
        total++; if ({done, gnt, busy, agen_out, tmo_err} !== 8'd0) begin bad++; $display("FAIL flush_idle got=%b exp=00000000", {done, gnt, busy, agen_out, tmo_err}); end
        req = 4'b1111;
        tick;
        total++; if ({sel, gnt} !== 6'b010010) begin bad++; $display("FAIL flush_ptr got=%b exp=010010", {sel, gnt}); end
    endtask

    task automatic test_reset_midop;
        int id;
        bit seen;
        req = '0;
        tick;
        total++; if ({busy, agen_out} !== 2'b10) begin bad++; $display("FAIL rstop_wait1 got=%b exp=10", {busy, agen_out}); end
        rst = 1'b1; tlb_v = 1'b1;
        tick;
        rst = 1'b0; tlb_v = 1'b0;
        total++; if ({gnt, sel, agen_out, agen_next, done, done_id, busy, tmo_err} !== 13'd0) begin
            bad++; $display("FAIL rstop_outputs got=%0h exp=0", {gnt, sel, agen_out, agen_next, done, done_id, busy, tmo_err});
        end
        req = 4'b1000;
        tick;
        total++; if ({sel, gnt, agen_out} !== 7'b1110001) begin bad++; $display("FAIL rstop_grant got=%b exp=1110001", {sel, gnt, agen_out}); end
        exp_q.push_back(3);
        req = '0; tlb_v = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick;
            if (done) seen = 1'b1;
        end
        tlb_v = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstop_done got=%0b exp=1", seen); end
        else if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            total++; if (done_id !== 2'(id)) begin bad++; $display("FAIL rstop_done_id got=%0d exp=%0d", done_id, id); end
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_xline;
        test_timeout;
        test_flush;
        test_reset_midop;
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qupls4_agen_sched.md
QUPLS4_AGEN_SCHED -- requirements
Module: Qupls4_agen_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one address generator.
REQ-002 SHALL have parameter TMO, default 16: cycles to wait for tlb_v before abandoning an op.
REQ-003 SHALL have port clk  in  1  clock; rst is synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port req  in  NREQ  requester i has an op ready for address generation.
REQ-006 SHALL have port xline  in  NREQ  op of requester i crosses a cache line and needs a second pass.
REQ-007 SHALL have port flush  in  1  abort the in-flight op.
REQ-008 SHALL have port tlb_v  in  1  TLB accepted the generated address.
REQ-009 SHALL have port gnt  out  NREQ  one-hot grant, which steers the agen operand mux.
REQ-010 SHALL have port sel  out  $clog2(NREQ)  index of the granted requester.
REQ-011 SHALL have port agen_out  out  1  one-cycle pulse that starts the agen.
REQ-012 SHALL have port agen_next  out  1  next-line pass qualifier, valid together with agen_out.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port done_id  out  $clog2(NREQ)  requester index, valid while done=1.
REQ-015 SHALL have port busy  out  1  state is not IDLE.
REQ-016 SHALL have port tmo_err  out  1  one-cycle timeout pulse.

Function
REQ-017 SHALL implement the states IDLE, REQ1, WAIT1, REQ2 and WAIT2, with all outputs registered.
REQ-018 IDLE: when any req bit is set, SHALL pick round-robin starting at ptr, register sel, gnt and xline[sel], then go to REQ1.
REQ-019 The round-robin ptr SHALL become (sel+1) mod NREQ on each grant, wrapping from NREQ-1 to 0.
REQ-020 REQ1 SHALL hold agen_out=1 and agen_next=0 for exactly one cycle, clear the timer, then go to WAIT1.
REQ-021 In WAIT1, tlb_v SHALL go to REQ2 if the latched xline is set; otherwise it SHALL pulse done, drive done_id=sel and go to IDLE.
REQ-022 REQ2 SHALL hold agen_out=1 and agen_next=1 for one cycle, clear the timer, then go to WAIT2.
REQ-023 In WAIT2, tlb_v SHALL pulse done, drive done_id=sel and go to IDLE.
REQ-024 In WAIT1 and WAIT2 the timer SHALL increment every cycle; at TMO-1 without tlb_v it SHALL pulse tmo_err, go to IDLE and not pulse done.
REQ-025 gnt SHALL hold from REQ1 through WAIT2 and be all-zero in IDLE.
REQ-026 done and tmo_err SHALL appear in the first IDLE cycle, and IDLE SHALL be able to arbitrate in that same cycle.
REQ-027 Minimum op period SHALL be 3 cycles without xline (REQ1, WAIT1+tlb_v, IDLE) and 5 cycles with xline.
REQ-028 tlb_v SHALL be ignored in IDLE, REQ1 and REQ2.
REQ-029 A change in req or xline after the grant SHALL be ignored until the op ends.
REQ-030 flush SHALL force IDLE on the next cycle from any state and drive gnt, agen_out, done and tmo_err to 0; ptr SHALL be unchanged.
REQ-031 flush SHALL take priority over a same-cycle tlb_v or timeout.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 Reset SHALL set state=IDLE, ptr=0 and timer=0, and drive gnt, sel, agen_out, agen_next, done, done_id, busy and tmo_err to 0.
REQ-034 Reset mid-op SHALL abandon the op without a done pulse, and reset SHALL take priority over flush.

Verification (NREQ=4, TMO=16)
REQ-035 req=4'b0100, xline=0, tlb_v 2 cycles after agen_out -> gnt=4'b0100, sel=2, one agen_out pulse with agen_next=0, then done=1 with done_id=2.
REQ-036 req=4'b1111 held, tlb_v in the cycle after each agen_out -> grant order 0,1,2,3,0 with a 3-cycle period.
REQ-037 req[1]=1 and xline[1]=1, tlb_v prompt on both passes -> two agen_out pulses, the second with agen_next=1, and exactly one done (done_id=1) after the second tlb_v.
REQ-038 req[3]=1 and no tlb_v -> tmo_err pulses 16 cycles after WAIT1 is entered, busy=0, no done, and the next grant starts at index 0.
REQ-039 flush asserted in WAIT2 together with tlb_v -> no done, next cycle IDLE with gnt=0, ptr unchanged.
REQ-040 rst asserted in WAIT1 -> all outputs 0 on the next cycle, and req=4'b1000 afterwards is granted to index 3.
